cv32e40p_obi_arbiter: RTL and testbench

Two-master OBI arbiter that shares one OBI memory port between the prefetch transaction interface (m1) and a second requester such as the debug/program-buffer or a second fetch source (m0). Selects one request per cycle, holds the selection stable through the OBI address phase, and records the owner of every accepted transaction in an in-order route FIFO. Responses are returned to the owning master. The block adds no latency: request, grant and response paths are combinational, and only the arbitration and bookkeeping state is registered.

---
 rtl/cv32e40p_obi_arbiter.sv | 129 ++++++++++++
 tb/tb_cv32e40p_obi_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_obi_arbiter.sv
// Two-master OBI arbiter: shares one OBI port between m0 and m1, holds the
// selection through the address phase and routes responses in order.
// Ports: clk/rst_n (async active-low); m0_*/m1_* master request, grant and
// response; obi_* memory port; m_rdata_o/m_err_o broadcast response; busy_o.
// Build option: define CV32E40P_OBI_ARB_ROUND_ROBIN_EN for round-robin
// priority on a conflict; otherwise m0 always wins.
module cv32e40p_obi_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req_i,
   input  logic [31:0] m0_addr_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_gnt_o,
   output logic        m0_rvalid_o,
   input  logic        m1_req_i,
   input  logic [31:0] m1_addr_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_gnt_o,
   output logic        m1_rvalid_o,
   output logic [31:0] m_rdata_o,
   output logic        m_err_o,
   output logic        obi_req_o,
   output logic [31:0] obi_addr_o,
   output logic        obi_we_o,
   output logic [3:0]  obi_be_o,
   output logic [31:0] obi_wdata_o,
   input  logic        obi_gnt_i,
   input  logic        obi_rvalid_i,
   input  logic [31:0] obi_rdata_i,
   input  logic        obi_err_i,
   output logic        busy_o
);

   localparam int unsigned PTR_W =
      (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   logic [CNT_W-1:0]           cnt_q;
   logic                       lock_q;
   logic                       lock_sel_q;
   logic [MAX_OUTSTANDING-1:0] route_q;
   logic [PTR_W-1:0]           wptr_q;
   logic [PTR_W-1:0]           rptr_q;
`ifdef CV32E40P_OBI_ARB_ROUND_ROBIN_EN
   logic                       last_q;
`endif

   logic issue_ok;
   logic arb_sel;
   logic sel;
   logic accept;
   logic resp;
   logic head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign issue_ok = (cnt_q < CNT_MAX);

   always_comb begin
      arb_sel = m1_req_i & ~m0_req_i;
`ifdef CV32E40P_OBI_ARB_ROUND_ROBIN_EN
      // On a conflict the master that did not win last time goes first.
      if (m0_req_i && m1_req_i) arb_sel = ~last_q;
`endif
   end

   assign sel       = lock_q ? lock_sel_q : arb_sel;
   assign obi_req_o = lock_q | (issue_ok & (m0_req_i | m1_req_i));

   assign obi_addr_o  = !obi_req_o ? '0 : (sel ? m1_addr_i  : m0_addr_i);
   assign obi_we_o    = !obi_req_o ? '0 : (sel ? m1_we_i    : m0_we_i);
   assign obi_be_o    = !obi_req_o ? '0 : (sel ? m1_be_i    : m0_be_i);
   assign obi_wdata_o = !obi_req_o ? '0 : (sel ? m1_wdata_i : m0_wdata_i);

   assign accept   = obi_req_o & obi_gnt_i;
   assign m0_gnt_o = accept & ~sel;
   assign m1_gnt_o = accept & sel;

   // A response with nothing outstanding is ignored entirely.
   assign resp        = obi_rvalid_i & (cnt_q != '0);
   assign head        = route_q[rptr_q];
   assign m0_rvalid_o = resp & ~head;
   assign m1_rvalid_o = resp & head;
   assign m_rdata_o   = obi_rdata_i;
   assign m_err_o     = obi_err_i;

   assign busy_o = (cnt_q != '0) | obi_req_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         lock_q     <= 1'b0;
         lock_sel_q <= 1'b0;
         route_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
`ifdef CV32E40P_OBI_ARB_ROUND_ROBIN_EN
         last_q     <= 1'b1;
`endif
      end else begin
         if (accept) begin
            route_q[wptr_q] <= sel;
            wptr_q          <= ptr_inc(wptr_q);
            lock_q          <= 1'b0;
`ifdef CV32E40P_OBI_ARB_ROUND_ROBIN_EN
            last_q          <= sel;
`endif
         end else if (obi_req_o) begin
            // Hold the address phase stable until memory grants it.
            lock_q     <= 1'b1;
            lock_sel_q <= sel;
         end
         if (resp) rptr_q <= ptr_inc(rptr_q);
         if (accept && !resp) cnt_q <= cnt_q + CNT_W'(1);
         else if (!accept && resp) cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cv32e40p_obi_arbiter.sv
// Scoreboard bench for cv32e40p_obi_arbiter: directed cycles push expected
// grants/responses; a negedge monitor pops and compares them.
module tb_cv32e40p_obi_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req_i, m1_req_i;
   logic [31:0] m0_addr_i, m1_addr_i;
   logic        m0_we_i, m1_we_i;
   logic [3:0]  m0_be_i, m1_be_i;
   logic [31:0] m0_wdata_i, m1_wdata_i;
   logic        m0_gnt_o, m1_gnt_o;
   logic        m0_rvalid_o, m1_rvalid_o;
   logic [31:0] m_rdata_o;
   logic        m_err_o;
   logic        obi_req_o;
   logic [31:0] obi_addr_o;
   logic        obi_we_o;
   logic [3:0]  obi_be_o;
   logic [31:0] obi_wdata_o;
   logic        obi_gnt_i, obi_rvalid_i;
   logic [31:0] obi_rdata_i;
   logic        obi_err_i;
   logic        busy_o;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic        who;
      logic [31:0] addr;
   } gnt_t;

   typedef struct packed {
      logic        who;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   gnt_t gq[$];
   rsp_t rq[$];

   always #5 clk = ~clk;

   cv32e40p_obi_arbiter #(.MAX_OUTSTANDING(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
      .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i),
      .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
      .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
      .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i),
      .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
      .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
      .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
      .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
      .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i),
      .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
      .busy_o(busy_o)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      gnt_t g;
      rsp_t r;
      if (m0_gnt_o || m1_gnt_o) begin
         if (gq.size() == 0) begin
            chk("gnt_unexpected", {m1_gnt_o, m0_gnt_o}, 64'd0);
         end else begin
            g = gq.pop_front();
            chk("gnt_route", {m1_gnt_o, m0_gnt_o}, g.who ? 2'b10 : 2'b01);
            chk("gnt_addr", obi_addr_o, g.addr);
         end
      end
      if (m0_rvalid_o || m1_rvalid_o) begin
         if (rq.size() == 0) begin
            chk("rvalid_unexpected", {m1_rvalid_o, m0_rvalid_o}, 64'd0);
         end else begin
            r = rq.pop_front();
            chk("rsp_route", {m1_rvalid_o, m0_rvalid_o},
                r.who ? 2'b10 : 2'b01);
            chk("rsp_data", {m_err_o, m_rdata_o}, {r.err, r.data});
         end
      end
   end

   task automatic idle();
      m0_req_i = 0; m0_addr_i = 0; m0_we_i = 0; m0_be_i = 0; m0_wdata_i = 0;
      m1_req_i = 0; m1_addr_i = 0; m1_we_i = 0; m1_be_i = 0; m1_wdata_i = 0;
      obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = 0; obi_err_i = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_ctl"},
          {obi_req_o, obi_we_o, obi_be_o, m0_gnt_o, m1_gnt_o,
           m0_rvalid_o, m1_rvalid_o, busy_o}, 64'd0);
      chk({name, "_addr"}, obi_addr_o, 64'd0);
      chk({name, "_wdata"}, obi_wdata_o, 64'd0);
   endtask

   initial begin : drv
      logic w;
      logic pw;
      idle();
      rst_n = 0;
      obi_rdata_i = 32'h1234_5678;
      obi_err_i = 1;
      tick();
      tick();
      #3;
      chk_quiet("reset");
      chk("reset_rdata", {m_err_o, m_rdata_o}, {1'b1, 32'h1234_5678});
      tick();
      rst_n = 1;
      idle();
      tick();

      // single m1 read
      m1_req_i = 1; m1_addr_i = 32'h100; m1_be_i = 4'hF; obi_gnt_i = 1;
      gq.push_back('{1'b1, 32'h100});
      #3;
      chk("t1_req", {obi_req_o, obi_be_o}, {1'b1, 4'hF});
      tick();
      idle();
      tick();
      obi_rvalid_i = 1; obi_rdata_i = 32'hDEAD_BEEF;
      rq.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0});
      tick();
      idle();
      tick();

      // both request every cycle, memory answers one cycle later
      pw = 0;
      for (int k = 0; k < 4; k++) begin
         idle();
         m0_req_i = 1; m0_addr_i = 32'h200 + 32'(k);
         m1_req_i = 1; m1_addr_i = 32'h300 + 32'(k);
         obi_gnt_i = 1;
`ifdef CV32E40P_OBI_ARB_ROUND_ROBIN_EN
         w = k[0];
`else
         w = 1'b0;
`endif
         gq.push_back('{w, w ? m1_addr_i : m0_addr_i});
         if (k > 0) begin
            obi_rvalid_i = 1; obi_rdata_i = 32'h1000 + 32'(k);
            rq.push_back('{pw, obi_rdata_i, 1'b0});
         end
         pw = w;
         tick();
      end
      idle();
      obi_rvalid_i = 1; obi_rdata_i = 32'h1004;
      rq.push_back('{pw, 32'h1004, 1'b0});
      tick();
      idle();
      tick();

      // m1 locked for three cycles while m0 joins
      m1_req_i = 1; m1_addr_i = 32'h400; m1_we_i = 1; m1_be_i = 4'h3;
      m1_wdata_i = 32'hCAFE;
      #3;
      chk("t3_addr0", obi_addr_o, 32'h400);
      chk("t3_pay", {obi_we_o, obi_be_o, obi_wdata_o},
          {1'b1, 4'h3, 32'hCAFE});
      tick();
      m0_req_i = 1; m0_addr_i = 32'h500;
      #3;
      chk("t3_addr1", obi_addr_o, 32'h400);
      tick();
      #3;
      chk("t3_addr2", obi_addr_o, 32'h400);
      tick();
      obi_gnt_i = 1;
      gq.push_back('{1'b1, 32'h400});
      tick();
      m1_req_i = 0; m1_we_i = 0; m1_be_i = 0; m1_wdata_i = 0;
      gq.push_back('{1'b0, 32'h500});
      tick();
      idle();
      obi_rvalid_i = 1; obi_rdata_i = 32'hA1; obi_err_i = 1;
      rq.push_back('{1'b1, 32'hA1, 1'b1});
      tick();
      obi_err_i = 0; obi_rdata_i = 32'hA2;
      rq.push_back('{1'b0, 32'hA2, 1'b0});
      tick();
      idle();
      tick();

      // outstanding limit
      m0_req_i = 1; m0_addr_i = 32'h600; obi_gnt_i = 1;
      gq.push_back('{1'b0, 32'h600});
      tick();
      m0_req_i = 0; m1_req_i = 1; m1_addr_i = 32'h700;
      gq.push_back('{1'b1, 32'h700});
      tick();
      m0_req_i = 1;
      #3;
      chk("t4_full_req", obi_req_o, 1'b0);
      chk("t4_full_busy", busy_o, 1'b1);
      tick();
      obi_rvalid_i = 1; obi_rdata_i = 32'hB1;
      rq.push_back('{1'b0, 32'hB1, 1'b0});
      #3;
      chk("t4_still_full", obi_req_o, 1'b0);
      tick();
      obi_rvalid_i = 0;
      gq.push_back('{1'b0, 32'h600});
      #3;
      chk("t4_slot_free", obi_req_o, 1'b1);
      tick();
      idle();
      obi_rvalid_i = 1; obi_rdata_i = 32'hB2;
      rq.push_back('{1'b1, 32'hB2, 1'b0});
      tick();
      obi_rdata_i = 32'hB3;
      rq.push_back('{1'b0, 32'hB3, 1'b0});
      tick();
      idle();
      tick();

      // grant and response in one cycle
      m1_req_i = 1; m1_addr_i = 32'h800; obi_gnt_i = 1;
      gq.push_back('{1'b1, 32'h800});
      tick();
      m1_req_i = 0; m1_addr_i = 0;
      m0_req_i = 1; m0_addr_i = 32'h900;
      obi_rvalid_i = 1; obi_rdata_i = 32'hC1;
      gq.push_back('{1'b0, 32'h900});
      rq.push_back('{1'b1, 32'hC1, 1'b0});
      tick();
      idle();
      obi_rvalid_i = 1; obi_rdata_i = 32'hC2;
      rq.push_back('{1'b0, 32'hC2, 1'b0});
      #3;
      chk("t5_cnt_kept", {busy_o, obi_req_o}, 2'b10);
      tick();
      idle();
      #3;
      chk("t5_drained", busy_o, 1'b0);
      tick();

      // stray response, then reset during a lock
      obi_rvalid_i = 1; obi_rdata_i = 32'hD1;
      #3;
      chk("t6_stray", {m1_rvalid_o, m0_rvalid_o, busy_o}, 3'b000);
      tick();
      idle();
      m1_req_i = 1; m1_addr_i = 32'hA00;
      tick();
      #3;
      chk("t6_locked", {obi_req_o, obi_addr_o}, {1'b1, 32'hA00});
      #2;
      idle();
      rst_n = 0;
      obi_rvalid_i = 1;
      #1;
      chk_quiet("t6_rst");
      tick();
      rst_n = 1;
      #3;
      chk("t6_post_stray", {m1_rvalid_o, m0_rvalid_o, busy_o}, 3'b000);
      tick();
      idle();
      m0_req_i = 1; m0_addr_i = 32'hB00; obi_gnt_i = 1;
      gq.push_back('{1'b0, 32'hB00});
      tick();
      idle();
      tick();
      obi_rvalid_i = 1; obi_rdata_i = 32'hE1;
      rq.push_back('{1'b0, 32'hE1, 1'b0});
      tick();
      idle();
      repeat (3) tick();

      chk("gq_drained", 64'(gq.size()), 64'd0);
      chk("rq_drained", 64'(rq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
